// File: rtl/i2c_xfer_arbiter_pkg.sv
// Shared types for the I2C transfer arbiter and the config sequencers
// (HDMI, audio codec) that feed it.
package i2c_xfer_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_END,
        RELEASE,
        DONE
    } xfer_state_e;

    typedef struct packed {
        logic [7:0] slave_addr;
        logic [7:0] sub_addr;
        logic [7:0] data;
    } xfer_word_t;

    localparam int XFER_W = $bits(xfer_word_t);

endpackage

// File: rtl/i2c_xfer_arbiter_rr_arbiter.sv
// One-hot round-robin pick: the first set request at or after (last_i + 1)
// wins, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest set
    // request overwrites the others; no early exit needed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_xfer_arbiter.sv
// Shares one I2C controller between NUM_REQ requesters: round-robin grant,
// NACK retry up to MAX_RETRY, and a WAIT_END watchdog of TIMEOUT_CYC cycles.
module i2c_xfer_arbiter
    import i2c_xfer_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [24*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]    GRANT,
    output logic [NUM_REQ-1:0]    RSP_DONE,
    output logic [NUM_REQ-1:0]    RSP_ERR,
    output logic [23:0]           I2C_DATA,
    output logic                  I2C_GO,
    input  logic                  I2C_END,
    input  logic                  I2C_ACK,
    output logic                  BUSY
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

    xfer_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    xfer_word_t          data_q, data_d;
    logic                go_q, go_d;
    logic                err_q, err_d;
    logic [2:0]          retry_q, retry_d;
    logic [CNT_W-1:0]    tcnt_q, tcnt_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    xfer_word_t          pick_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i   (REQ_VALID),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) pick_data = REQ_DATA[24*i +: 24];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking
    // ones here would let later statements see half-updated state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
            go_q    <= 1'b0;
            err_q   <= 1'b0;
            retry_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            go_q    <= go_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        go_d    = go_q;
        err_d   = err_q;
        retry_d = retry_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    data_d  = pick_data;
                    retry_d = '0;
                    tcnt_d  = '0;
                    state_d = ISSUE;
                end
            end
            // GO is held back while the controller still shows the previous END.
            ISSUE: begin
                if (!I2C_END) begin
                    go_d    = 1'b1;
                    tcnt_d  = '0;
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (I2C_END) begin
                    go_d = 1'b0;
                    if (!I2C_ACK) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 3'd1;
                        state_d = RELEASE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    go_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!I2C_END) state_d = ISSUE;
            end
            DONE: begin
                last_d  = owner_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign GRANT    = grant_q;
    assign I2C_GO   = go_q;
    assign I2C_DATA = data_q;
    assign BUSY     = (state_q != IDLE);
    assign RSP_DONE = (state_q == DONE) ? grant_q : '0;
    assign RSP_ERR  = (state_q == DONE && err_q) ? grant_q : '0;

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Self-checking bench for i2c_xfer_arbiter: behavioural I2C controller,
// round-robin reference model and randomized transfers.
module tb_i2c_xfer_arbiter;

    localparam int N  = 2;
    localparam int MR = 3;
    localparam int TO = 16;

    logic            iCLK = 1'b0;
    logic            iRST_N = 1'b0;
    logic [N-1:0]    REQ_VALID = '0;
    logic [24*N-1:0] REQ_DATA = '0;
    logic [N-1:0]    GRANT, RSP_DONE, RSP_ERR;
    logic [23:0]     I2C_DATA;
    logic            I2C_GO, BUSY;
    logic            I2C_END = 1'b0;
    logic            I2C_ACK = 1'b0;

    i2c_xfer_arbiter #(.NUM_REQ(N), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .GRANT(GRANT), .RSP_DONE(RSP_DONE), .RSP_ERR(RSP_ERR), .I2C_DATA(I2C_DATA),
        .I2C_GO(I2C_GO), .I2C_END(I2C_END), .I2C_ACK(I2C_ACK), .BUSY(BUSY)
    );

    always #5 iCLK = ~iCLK;

    int tests_run = 0;
    int tests_failed = 0;

    int ctl_delay = 0;
    int ctl_nacks_left = 0;
    int ctl_wait = 0;
    bit ctl_never = 1'b0;

    int          grant_q[$];
    int          done_q[$];
    bit          err_q[$];
    int          go_rises = 0;
    int          go_len = 0;
    int          go_cur = 0;
    logic [23:0] go_data = '0;
    logic [N-1:0] grant_prev = '0;
    logic        go_prev = 1'b0;
    int          model_last = N - 1;

    function automatic int onehot_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Controller model: answers each GO after ctl_delay cycles, NACKing while
    // ctl_nacks_left > 0, and holds END until GO drops.
    initial forever begin
        @(negedge iCLK);
        if (!iRST_N) begin
            I2C_END  = 1'b0;
            ctl_wait = 0;
        end else if (I2C_END) begin
            if (!I2C_GO) I2C_END = 1'b0;
        end else if (I2C_GO && !ctl_never) begin
            if (ctl_wait >= ctl_delay) begin
                I2C_END  = 1'b1;
                I2C_ACK  = (ctl_nacks_left > 0);
                if (ctl_nacks_left > 0) ctl_nacks_left--;
                ctl_wait = 0;
            end else begin
                ctl_wait++;
            end
        end
    end

    // Monitor just after each active edge.
    initial forever begin
        @(posedge iCLK);
        #1;
        if (GRANT != '0 && grant_prev == '0) grant_q.push_back(onehot_idx(GRANT));
        grant_prev = GRANT;
        if (I2C_GO && !go_prev) begin
            go_rises++;
            go_data = I2C_DATA;
            go_cur  = 0;
        end
        if (I2C_GO) go_cur++;
        if (!I2C_GO && go_prev) go_len = go_cur;
        go_prev = I2C_GO;
        if (RSP_DONE != '0) begin
            done_q.push_back(onehot_idx(RSP_DONE));
            err_q.push_back(|(RSP_ERR & RSP_DONE));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        grant_q.delete();
        done_q.delete();
        err_q.delete();
        go_rises = 0;
        go_len   = 0;
    endtask

    task automatic apply_reset();
        REQ_VALID = '0;
        iRST_N = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        model_last = N - 1;
        clear_mon();
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (done_q.size() < n && c < budget) begin
            @(negedge iCLK);
            c++;
        end
        if (done_q.size() < n) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: RSP_DONE count %0d, required %0d within %0d cycles",
                     tag, done_q.size(), n, budget);
        end
    endtask

    task automatic do_xfer(input logic [N-1:0] mask, input int nacks, input bit never,
                           input int delay, input string tag,
                           output int owner, output bit err, output int gos,
                           output logic [23:0] data, output int glen, output int ndone);
        clear_mon();
        ctl_nacks_left = nacks;
        ctl_never      = never;
        ctl_delay      = delay;
        REQ_VALID      = mask;
        wait_dones(1, 400, tag);
        REQ_VALID = '0;
        repeat (3) @(negedge iCLK);
        owner = (done_q.size() > 0) ? done_q[0] : -1;
        err   = (err_q.size() > 0) ? err_q[0] : 1'b0;
        gos   = go_rises;
        data  = go_data;
        glen  = go_len;
        ndone = done_q.size();
        ctl_never = 1'b0;
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        @(negedge iCLK);
        tests_run++;
        if ({GRANT, RSP_DONE, RSP_ERR} !== '0) begin
            tests_failed++;
            $display("FAIL reset_vec: GRANT/DONE/ERR=%b required 0", {GRANT, RSP_DONE, RSP_ERR});
        end
        tests_run++;
        if (I2C_GO !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_go_busy: GO=%b BUSY=%b required 0 0", I2C_GO, BUSY);
        end
        tests_run++;
        if (I2C_DATA !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: I2C_DATA=%h required 000000", I2C_DATA);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int owner, gos, glen, nd, exp_owner;
        bit err;
        logic [23:0] data;
        REQ_DATA[23:0]  = 24'h729803;
        REQ_DATA[47:24] = 24'($urandom);
        exp_owner = rr_pick(2'b01, model_last);
        do_xfer(2'b01, 0, 1'b0, 2, "single", owner, err, gos, data, glen, nd);
        tests_run++;
        if (owner !== exp_owner || nd !== 1) begin
            tests_failed++;
            $display("FAIL single_done: owner=%0d pulses=%0d required %0d 1", owner, nd, exp_owner);
        end
        tests_run++;
        if (err !== 1'b0 || gos !== 1) begin
            tests_failed++;
            $display("FAIL single_go: err=%b gos=%0d required 0 1", err, gos);
        end
        tests_run++;
        if (data !== 24'h729803) begin
            tests_failed++;
            $display("FAIL single_data: I2C_DATA=%h required 729803", data);
        end
        model_last = exp_owner;
    endtask

    task automatic test_contention();
        int exp;
        apply_reset();
        ctl_nacks_left = 0;
        ctl_never = 1'b0;
        ctl_delay = 1;
        REQ_VALID = 2'b11;
        wait_dones(4, 600, "contention");
        REQ_VALID = '0;
        repeat (3) @(negedge iCLK);
        tests_run++;
        if (grant_q.size() !== 4 || done_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL contention_count: grants=%0d dones=%0d required 4 4",
                     grant_q.size(), done_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp = rr_pick(2'b11, model_last);
            tests_run++;
            if (i < grant_q.size() && grant_q[i] !== exp) begin
                tests_failed++;
                $display("FAIL contention_order[%0d]: grant=%0d required %0d", i, grant_q[i], exp);
            end
            model_last = exp;
        end
    endtask

    task automatic test_nack();
        int owner, gos, glen, nd, exp_owner;
        bit err;
        logic [23:0] data;
        exp_owner = rr_pick(2'b10, model_last);
        do_xfer(2'b10, 100, 1'b0, 0, "nack", owner, err, gos, data, glen, nd);
        tests_run++;
        if (gos !== MR + 1 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL nack: gos=%0d err=%b required %0d 1", gos, err, MR + 1);
        end
        tests_run++;
        if (owner !== exp_owner || data !== REQ_DATA[47:24]) begin
            tests_failed++;
            $display("FAIL nack_owner: owner=%0d data=%h required %0d %h",
                     owner, data, exp_owner, REQ_DATA[47:24]);
        end
        model_last = exp_owner;
    endtask

    task automatic test_retry_recover();
        int owner, gos, glen, nd, exp_owner;
        bit err;
        logic [23:0] data;
        exp_owner = rr_pick(2'b11, model_last);
        do_xfer(2'b11, MR, 1'b0, 1, "retry_recover", owner, err, gos, data, glen, nd);
        tests_run++;
        if (gos !== MR + 1 || err !== 1'b0 || owner !== exp_owner) begin
            tests_failed++;
            $display("FAIL retry_recover: gos=%0d err=%b owner=%0d required %0d 0 %0d",
                     gos, err, owner, MR + 1, exp_owner);
        end
        model_last = exp_owner;
    endtask

    task automatic test_timeout();
        int owner, gos, glen, nd, exp_owner;
        bit err;
        logic [23:0] data;
        exp_owner = rr_pick(2'b01, model_last);
        do_xfer(2'b01, 0, 1'b1, 0, "timeout", owner, err, gos, data, glen, nd);
        tests_run++;
        if (glen !== TO || gos !== 1) begin
            tests_failed++;
            $display("FAIL timeout_len: GO high %0d cycles, gos=%0d required %0d 1", glen, gos, TO);
        end
        tests_run++;
        if (err !== 1'b1 || owner !== exp_owner) begin
            tests_failed++;
            $display("FAIL timeout_err: err=%b owner=%0d required 1 %0d", err, owner, exp_owner);
        end
        model_last = exp_owner;
    endtask

    task automatic test_reset_mid();
        int owner, gos, glen, nd, c;
        bit err;
        logic [23:0] data;
        clear_mon();
        ctl_never = 1'b1;
        REQ_VALID = 2'b10;
        c = 0;
        while (!I2C_GO && c < 50) begin
            @(negedge iCLK);
            c++;
        end
        tests_run++;
        if (I2C_GO !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_go: GO=%b required 1 before reset", I2C_GO);
        end
        repeat (3) @(negedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        tests_run++;
        if (I2C_GO !== 1'b0 || GRANT !== '0 || BUSY !== 1'b0 || I2C_DATA !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: GO=%b GRANT=%b BUSY=%b DATA=%h required 0 00 0 000000",
                     I2C_GO, GRANT, BUSY, I2C_DATA);
        end
        REQ_VALID = '0;
        ctl_never = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        model_last = N - 1;
        do_xfer(2'b11, 0, 1'b0, 0, "reset_mid", owner, err, gos, data, glen, nd);
        tests_run++;
        if (owner !== rr_pick(2'b11, N - 1) || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_first: owner=%0d err=%b required %0d 0",
                     owner, err, rr_pick(2'b11, N - 1));
        end
        model_last = rr_pick(2'b11, N - 1);
    endtask

    task automatic test_random();
        int owner, gos, glen, nd, exp_owner, nacks, exp_gos;
        bit err, exp_err;
        logic [23:0] data, exp_data;
        logic [N-1:0] mask;
        for (int r = 0; r < 12; r++) begin
            mask  = N'($urandom_range(1, (1 << N) - 1));
            nacks = $urandom_range(0, 5);
            REQ_DATA = {24'($urandom), 24'($urandom)};
            exp_owner = rr_pick(mask, model_last);
            exp_data  = REQ_DATA[24*exp_owner +: 24];
            exp_err   = (nacks > MR);
            exp_gos   = exp_err ? MR + 1 : nacks + 1;
            do_xfer(mask, nacks, 1'b0, $urandom_range(0, 3), "random",
                    owner, err, gos, data, glen, nd);
            tests_run++;
            if (owner !== exp_owner || err !== exp_err || gos !== exp_gos
                || data !== exp_data || nd !== 1) begin
                tests_failed++;
                $display("FAIL random[%0d]: owner=%0d err=%b gos=%0d data=%h pulses=%0d required %0d %b %0d %h 1",
                         r, owner, err, gos, data, nd, exp_owner, exp_err, exp_gos, exp_data);
            end
            model_last = exp_owner;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_nack();
        test_retry_recover();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
